// File: rtl/demux_buffered.sv
// demux_buffered: steers one valid/ready producer stream to one of two
// consumer ports by a per-word select bit. Each port has its own DEPTH-entry
// FIFO, so a stalled consumer only blocks words bound for its own port.
// Optional statistics (pop counters, sticky stall flag) are built when the
// macro DEMUX_STATS_EN is defined; the default build leaves them out.
module demux_buffered #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic             full0,
    output logic             full1,
    output logic             empty0,
    output logic             empty1
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1,
    output logic             drop_stall
`endif
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] r_mem0 [DEPTH];
    logic [WIDTH-1:0] r_mem1 [DEPTH];
    logic [PTR_W-1:0] r_wr0, r_rd0, r_wr1, r_rd1;
    logic [PTR_W:0]   r_cnt0, r_cnt1;

    logic w_full0, w_full1, w_empty0, w_empty1;
    logic w_ready, w_push0, w_push1, w_pop0, w_pop1;

    // Status flags, the handshake decode and the head-of-FIFO outputs.
    // Acceptance looks only at the FIFO the current word is bound for, and
    // the output side reads registered storage, so input never reaches
    // output combinationally.
    always_comb begin
        w_full0  = (r_cnt0 == CNT_FULL);
        w_full1  = (r_cnt1 == CNT_FULL);
        w_empty0 = (r_cnt0 == '0);
        w_empty1 = (r_cnt1 == '0);
        w_ready  = in_sel ? !w_full1 : !w_full0;
        w_push0  = in_valid && w_ready && !in_sel;
        w_push1  = in_valid && w_ready &&  in_sel;
        w_pop0   = !w_empty0 && out0_ready;
        w_pop1   = !w_empty1 && out1_ready;
    end

    assign in_ready   = w_ready;
    assign out0_data  = r_mem0[r_rd0];
    assign out1_data  = r_mem1[r_rd1];
    assign out0_valid = !w_empty0;
    assign out1_valid = !w_empty1;
    assign full0      = w_full0;
    assign full1      = w_full1;
    assign empty0     = w_empty0;
    assign empty1     = w_empty1;

    // FIFO 0: write at wr_ptr on push, advance rd_ptr on pop; pointers wrap
    // naturally because DEPTH is a power of two. Reset wipes storage so the
    // head reads zero afterwards and stale words cannot resurface.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr0  <= '0;
            r_rd0  <= '0;
            r_cnt0 <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem0[i] <= '0;
            end
        end else begin
            if (w_push0) begin
                r_mem0[r_wr0] <= in_data;
                r_wr0         <= r_wr0 + PTR_ONE;
            end
            if (w_pop0) begin
                r_rd0 <= r_rd0 + PTR_ONE;
            end
            case ({w_push0, w_pop0})
                2'b10:   r_cnt0 <= r_cnt0 + CNT_ONE;
                2'b01:   r_cnt0 <= r_cnt0 - CNT_ONE;
                default: r_cnt0 <= r_cnt0;
            endcase
        end
    end

    // FIFO 1: identical bookkeeping, fully independent of FIFO 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr1  <= '0;
            r_rd1  <= '0;
            r_cnt1 <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem1[i] <= '0;
            end
        end else begin
            if (w_push1) begin
                r_mem1[r_wr1] <= in_data;
                r_wr1         <= r_wr1 + PTR_ONE;
            end
            if (w_pop1) begin
                r_rd1 <= r_rd1 + PTR_ONE;
            end
            case ({w_push1, w_pop1})
                2'b10:   r_cnt1 <= r_cnt1 + CNT_ONE;
                2'b01:   r_cnt1 <= r_cnt1 - CNT_ONE;
                default: r_cnt1 <= r_cnt1;
            endcase
        end
    end

`ifdef DEMUX_STATS_EN
    logic [15:0] r_stat0, r_stat1;
    logic        r_drop;

    // Pop counters wrap at 16 bits; the stall flag latches any cycle where a
    // word was offered but could not be taken, and only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat0 <= '0;
            r_stat1 <= '0;
            r_drop  <= 1'b0;
        end else begin
            if (w_pop0) begin
                r_stat0 <= r_stat0 + 16'd1;
            end
            if (w_pop1) begin
                r_stat1 <= r_stat1 + 16'd1;
            end
            if (in_valid && !w_ready) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign cnt0       = r_stat0;
    assign cnt1       = r_stat1;
    assign drop_stall = r_drop;
`endif

endmodule

// File: tb/tb_demux_buffered.sv
// Bench for demux_buffered: directed scenarios with literal expectations,
// then a long randomized run. A queue-based model of the two ports is
// checked against the DUT on every falling edge.
module tb_demux_buffered;

    localparam int WIDTH = 10;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic             full0, full1, empty0, empty1;
`ifdef DEMUX_STATS_EN
    logic [15:0]      cnt0, cnt1;
    logic             drop_stall;
`endif

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: one queue per port in acceptance order, plus
    // whether the port has popped since reset (until then an empty head
    // still reads the cleared storage value of zero).
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    bit               popped0, popped1;
    bit               live = 1'b0;
    logic [15:0]      mCnt0, mCnt1;
    bit               mDrop;

    always #5 clk = ~clk;

    demux_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .full0      (full0),
        .full1      (full1),
        .empty0     (empty0),
        .empty1     (empty1)
`ifdef DEMUX_STATS_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .drop_stall (drop_stall)
`endif
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive all producer/consumer inputs at once.
    task automatic applyStimulus(input bit r, input bit v, input bit s,
                                 input logic [WIDTH-1:0] d,
                                 input bit rd0, input bit rd1);
        rst        = r;
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = rd0;
        out1_ready = rd1;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every falling edge: compare DUT outputs with the model, then advance
    // the model by what the coming rising edge must do with the inputs
    // currently applied.
    always @(negedge clk) begin
        bit expReady;
        bit doPush;
        if (live) begin
            checkOutput("out0_valid", 16'(out0_valid), 16'(q0.size() != 0));
            checkOutput("out1_valid", 16'(out1_valid), 16'(q1.size() != 0));
            if (q0.size() != 0)
                checkOutput("out0_data", 16'(out0_data), 16'(q0[0]));
            else if (!popped0)
                checkOutput("out0_data_clear", 16'(out0_data), 16'd0);
            if (q1.size() != 0)
                checkOutput("out1_data", 16'(out1_data), 16'(q1[0]));
            else if (!popped1)
                checkOutput("out1_data_clear", 16'(out1_data), 16'd0);
            checkOutput("full0", 16'(full0), 16'(q0.size() == DEPTH));
            checkOutput("full1", 16'(full1), 16'(q1.size() == DEPTH));
            checkOutput("empty0", 16'(empty0), 16'(q0.size() == 0));
            checkOutput("empty1", 16'(empty1), 16'(q1.size() == 0));
            expReady = in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
            checkOutput("in_ready", 16'(in_ready), 16'(expReady));
`ifdef DEMUX_STATS_EN
            checkOutput("cnt0", cnt0, mCnt0);
            checkOutput("cnt1", cnt1, mCnt1);
            checkOutput("drop_stall", 16'(drop_stall), 16'(mDrop));
`endif
        end
        if (rst) begin
            q0.delete();
            q1.delete();
            popped0 = 1'b0;
            popped1 = 1'b0;
            mCnt0   = '0;
            mCnt1   = '0;
            mDrop   = 1'b0;
            live    = 1'b1;
        end else if (live) begin
            expReady = in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
            doPush   = in_valid && expReady;
            if (in_valid && !expReady) mDrop = 1'b1;
            if (q0.size() != 0 && out0_ready) begin
                void'(q0.pop_front());
                popped0 = 1'b1;
                mCnt0   = mCnt0 + 16'd1;
            end
            if (q1.size() != 0 && out1_ready) begin
                void'(q1.pop_front());
                popped1 = 1'b1;
                mCnt1   = mCnt1 + 16'd1;
            end
            if (doPush) begin
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
            end
        end
    end

    initial begin
        bit lastAcc;
        bit hold;

        // Reset held two cycles while the producer is already offering.
        applyStimulus(1, 1, 0, 10'd5, 0, 0);
        tick();
        tick();
        applyStimulus(0, 0, 0, 10'd0, 0, 0);
        checkOutput("rst_out0_valid", 16'(out0_valid), 16'd0);
        checkOutput("rst_out1_valid", 16'(out1_valid), 16'd0);
        checkOutput("rst_out0_data", 16'(out0_data), 16'd0);
        checkOutput("rst_out1_data", 16'(out1_data), 16'd0);
        checkOutput("rst_in_ready", 16'(in_ready), 16'd1);
        checkOutput("rst_empty0", 16'(empty0), 16'd1);
        checkOutput("rst_empty1", 16'(empty1), 16'd1);
        checkOutput("rst_full0", 16'(full0), 16'd0);

        // Steering: 15 to port 0, 17 to port 1, no consumer ready.
        applyStimulus(0, 1, 0, 10'd15, 0, 0);
        tick();
        checkOutput("steer_out0_valid", 16'(out0_valid), 16'd1);
        checkOutput("steer_out0_data", 16'(out0_data), 16'd15);
        checkOutput("steer_out1_idle", 16'(out1_valid), 16'd0);
        applyStimulus(0, 1, 1, 10'd17, 0, 0);
        tick();
        checkOutput("steer_out1_valid", 16'(out1_valid), 16'd1);
        checkOutput("steer_out1_data", 16'(out1_data), 16'd17);
        checkOutput("steer_out0_keep", 16'(out0_data), 16'd15);
        applyStimulus(0, 0, 0, 10'd0, 1, 1);
        tick();
        checkOutput("steer_drained0", 16'(empty0), 16'd1);
        checkOutput("steer_drained1", 16'(empty1), 16'd1);

        // Backpressure: 1,2 fill port 0; 3 must wait for the first pop.
        applyStimulus(0, 1, 0, 10'd1, 0, 0);
        tick();
        applyStimulus(0, 1, 0, 10'd2, 0, 0);
        tick();
        checkOutput("bp_full0", 16'(full0), 16'd1);
        applyStimulus(0, 1, 0, 10'd3, 0, 0);
        #1;
        checkOutput("bp_in_ready_full", 16'(in_ready), 16'd0);
        tick();
        checkOutput("bp_head_1", 16'(out0_data), 16'd1);
        applyStimulus(0, 1, 0, 10'd3, 1, 0);
        #1;
        checkOutput("bp_ready_full_pop", 16'(in_ready), 16'd0);
        tick();
        checkOutput("bp_head_2", 16'(out0_data), 16'd2);
        checkOutput("bp_not_full", 16'(full0), 16'd0);
        checkOutput("bp_ready_again", 16'(in_ready), 16'd1);
        tick();
        checkOutput("bp_head_3", 16'(out0_data), 16'd3);
        checkOutput("bp_valid_3", 16'(out0_valid), 16'd1);
        applyStimulus(0, 0, 0, 10'd0, 1, 0);
        tick();
        checkOutput("bp_drained", 16'(empty0), 16'd1);

        // Independence: port 1 full and stalled, port 0 still accepts 99.
        applyStimulus(0, 1, 1, 10'd5, 0, 0);
        tick();
        applyStimulus(0, 1, 1, 10'd6, 0, 0);
        tick();
        checkOutput("ind_full1", 16'(full1), 16'd1);
        applyStimulus(0, 1, 0, 10'd99, 0, 0);
        #1;
        checkOutput("ind_in_ready", 16'(in_ready), 16'd1);
        tick();
        checkOutput("ind_out0_data", 16'(out0_data), 16'd99);
        checkOutput("ind_full1_kept", 16'(full1), 16'd1);
        checkOutput("ind_out1_head", 16'(out1_data), 16'd5);
        applyStimulus(0, 0, 0, 10'd0, 1, 1);
        tick();
        tick();
        checkOutput("ind_empty0", 16'(empty0), 16'd1);
        checkOutput("ind_empty1", 16'(empty1), 16'd1);

        // Reset mid-operation with words in both FIFOs and an offer pending.
        applyStimulus(0, 1, 0, 10'd7, 0, 0);
        tick();
        applyStimulus(0, 1, 1, 10'd8, 0, 0);
        tick();
        applyStimulus(1, 1, 0, 10'd9, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 10'd0, 1, 1);
        checkOutput("mid_empty0", 16'(empty0), 16'd1);
        checkOutput("mid_empty1", 16'(empty1), 16'd1);
        checkOutput("mid_out0_data", 16'(out0_data), 16'd0);
        checkOutput("mid_out1_data", 16'(out1_data), 16'd0);
        checkOutput("mid_in_ready", 16'(in_ready), 16'd1);
        tick();
        checkOutput("mid_stale0", 16'(out0_valid), 16'd0);
        checkOutput("mid_stale1", 16'(out1_valid), 16'd0);

        // Wrap: 8 words alternating ports, both consumers always ready.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, k[0], 10'(100 + k), 1, 1);
            tick();
            if (k[0]) begin
                checkOutput("wrap_valid1", 16'(out1_valid), 16'd1);
                checkOutput("wrap_data1", 16'(out1_data), 16'(100 + k));
            end else begin
                checkOutput("wrap_valid0", 16'(out0_valid), 16'd1);
                checkOutput("wrap_data0", 16'(out0_data), 16'(100 + k));
            end
        end
        applyStimulus(0, 0, 0, 10'd0, 1, 1);
        tick();
        checkOutput("wrap_empty0", 16'(empty0), 16'd1);
        checkOutput("wrap_empty1", 16'(empty1), 16'd1);
`ifdef DEMUX_STATS_EN
        checkOutput("wrap_cnt0", cnt0, 16'd4);
        checkOutput("wrap_cnt1", cnt1, 16'd4);
        checkOutput("wrap_drop", 16'(drop_stall), 16'd0);
`endif

        // Randomized run; a refused offer is held until it is accepted,
        // and consumer readiness alternates between sparse and dense epochs.
        lastAcc = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            hold = in_valid && !lastAcc && !rst;
            rst  = ($urandom_range(0, 249) == 0);
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 1'($urandom_range(0, 1));
                in_data  = 10'($urandom);
            end
            if (((c / 400) % 2) == 0) begin
                out0_ready = ($urandom_range(0, 3) == 0);
                out1_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out0_ready = ($urandom_range(0, 3) != 0);
                out1_ready = ($urandom_range(0, 1) == 0);
            end
            #3;
            lastAcc = in_valid && in_ready;
            tick();
        end

        applyStimulus(0, 0, 0, 10'd0, 0, 0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCompared, nMismatched);
        $finish;
    end

endmodule
